// File: rtl/mtp_issue_unit.sv
// ---------------------------------------------------------------------------
// mtp_issue_unit
//   Multi-threaded vector issue stage. Decoded instructions from ifetch are
//   buffered in one FIFO per hardware thread. Each thread keeps a scoreboard
//   of vector registers that have an issued but not yet written-back result.
//   Every cycle one ready thread is chosen round-robin, and its head
//   instruction goes out to the lowest-index free lane.
//
// Ports
//   clk, reset                 core clock, asynchronous active-low reset
//   thread_en                  per-thread issue enable
//   enq_vld/tid/op/dst/src*    enqueue one instruction into FIFO[enq_tid]
//   enq_err                    1-cycle pulse: the last enqueue hit a full FIFO
//   thread_full/thread_empty   per-thread FIFO status (registered count)
//   lane_busy                  lanes that cannot accept work this cycle
//   iss_vld/lane_sel/tid/...   registered issue, 1 cycle after the decision
//   wb_vld/wb_tid/wb_dst       writeback; clears one scoreboard bit
// ---------------------------------------------------------------------------

// Per-thread instruction FIFO plus register scoreboard. It tells the top
// level whether its head instruction is free of hazards.
module mtp_thread_q #(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_VREG   = 32,
    parameter int OP_W       = 8,
    parameter int RW         = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  push,
    input  logic [OP_W+3*RW-1:0]  push_ins,
    input  logic                  pop,
    input  logic                  wb_clr,
    input  logic [RW-1:0]         wb_dst,
    output logic                  full,
    output logic                  empty,
    output logic                  eligible,
    output logic [OP_W+3*RW-1:0]  head
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [RW-1:0]   dst;
        logic [RW-1:0]   src0;
        logic [RW-1:0]   src1;
    } ins_t;

    ins_t                mem [FIFO_DEPTH];
    ins_t                hd;
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic [CW-1:0]       count;
    logic [NUM_VREG-1:0] sb, sb_nxt;
    logic                wr_en;

    assign hd    = mem[rd_ptr];
    assign head  = hd;
    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    // Full comes from the registered count, so a pop in the same cycle
    // does not make room for a push.
    assign wr_en = push && !full;

    assign eligible = en && !empty && !sb[hd.dst] && !sb[hd.src0] && !sb[hd.src1];

    // The clear is applied first and the set second, so when both hit the
    // same bit at one edge the bit ends up set.
    always_comb begin
        sb_nxt = sb;
        if (wb_clr) sb_nxt[wb_dst] = 1'b0;
        if (pop)    sb_nxt[hd.dst] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= ins_t'(push_ins);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            sb     <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(wr_en) - CW'(pop);
            sb    <= sb_nxt;
        end
    end

endmodule

module mtp_issue_unit #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int NUM_VREG    = 32,
    parameter int OP_W        = 8,
    localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    localparam int RW = $clog2(NUM_VREG)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_THREADS-1:0] thread_en,
    input  logic                   enq_vld,
    input  logic [TW-1:0]          enq_tid,
    input  logic [OP_W-1:0]        enq_op,
    input  logic [RW-1:0]          enq_dst,
    input  logic [RW-1:0]          enq_src0,
    input  logic [RW-1:0]          enq_src1,
    output logic                   enq_err,
    output logic [NUM_THREADS-1:0] thread_full,
    output logic [NUM_THREADS-1:0] thread_empty,
    input  logic [NUM_LANES-1:0]   lane_busy,
    output logic                   iss_vld,
    output logic [NUM_LANES-1:0]   iss_lane_sel,
    output logic [TW-1:0]          iss_tid,
    output logic [OP_W-1:0]        iss_op,
    output logic [RW-1:0]          iss_dst,
    output logic [RW-1:0]          iss_src0,
    output logic [RW-1:0]          iss_src1,
    input  logic                   wb_vld,
    input  logic [TW-1:0]          wb_tid,
    input  logic [RW-1:0]          wb_dst
);

    localparam int IW = OP_W + 3 * RW;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [RW-1:0]   dst;
        logic [RW-1:0]   src0;
        logic [RW-1:0]   src1;
    } ins_t;

    logic [NUM_THREADS-1:0]         elig, pop;
    logic [NUM_THREADS-1:0][IW-1:0] head;
    logic [TW-1:0]                  rr_ptr, win, rr_nxt;
    logic                           any_elig, lane_found, issue_go, enq_err_c;
    logic [NUM_LANES-1:0]           reserved, free_lanes, lane_oh;
    ins_t                           sel;
    int                             idx;

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
        mtp_thread_q #(
            .FIFO_DEPTH (FIFO_DEPTH),
            .NUM_VREG   (NUM_VREG),
            .OP_W       (OP_W),
            .RW         (RW)
        ) u_q (
            .clk      (clk),
            .reset    (reset),
            .en       (thread_en[t]),
            .push     (enq_vld && (enq_tid == TW'(t))),
            .push_ins ({enq_op, enq_dst, enq_src0, enq_src1}),
            .pop      (pop[t]),
            .wb_clr   (wb_vld && (wb_tid == TW'(t))),
            .wb_dst   (wb_dst),
            .full     (thread_full[t]),
            .empty    (thread_empty[t]),
            .eligible (elig[t]),
            .head     (head[t])
        );
    end

    // A lane issued last cycle has not yet raised lane_busy, so it is held
    // off for one cycle. The lane-select register is exactly that mask.
    assign reserved   = iss_lane_sel;
    assign free_lanes = ~lane_busy & ~reserved;

    // Round-robin: scan from rr_ptr upward, wrapping, and take the first
    // eligible thread.
    always_comb begin
        any_elig = 1'b0;
        win      = '0;
        idx      = 0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_THREADS) idx = idx - NUM_THREADS;
            if (!any_elig && elig[idx]) begin
                any_elig = 1'b1;
                win      = TW'(idx);
            end
        end
    end

    always_comb begin
        lane_found = 1'b0;
        lane_oh    = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (!lane_found && free_lanes[l]) begin
                lane_found = 1'b1;
                lane_oh[l] = 1'b1;
            end
        end
    end

    assign issue_go = any_elig && lane_found;
    assign sel      = ins_t'(head[win]);
    assign rr_nxt   = (win == TW'(NUM_THREADS - 1)) ? '0 : win + TW'(1);

    always_comb begin
        pop       = '0;
        enq_err_c = 1'b0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            pop[i]    = issue_go && (win == TW'(i));
            enq_err_c = enq_err_c | (enq_vld && (enq_tid == TW'(i)) && thread_full[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr       <= '0;
            iss_vld      <= 1'b0;
            iss_lane_sel <= '0;
            iss_tid      <= '0;
            iss_op       <= '0;
            iss_dst      <= '0;
            iss_src0     <= '0;
            iss_src1     <= '0;
            enq_err      <= 1'b0;
        end else begin
            iss_vld      <= issue_go;
            iss_lane_sel <= issue_go ? lane_oh : '0;
            enq_err      <= enq_err_c;
            // Without a decision the payload holds and rr_ptr stays put.
            if (issue_go) begin
                rr_ptr   <= rr_nxt;
                iss_tid  <= win;
                iss_op   <= sel.op;
                iss_dst  <= sel.dst;
                iss_src0 <= sel.src0;
                iss_src1 <= sel.src1;
            end
        end
    end

endmodule

// File: tb/tb_mtp_issue_unit.sv
module tb_mtp_issue_unit;

    localparam int NT = 4, NL = 4, DEPTH = 4;

    logic       clk = 1'b0, reset = 1'b0;
    logic [3:0] thread_en = '0;
    logic       enq_vld = 1'b0;
    logic [1:0] enq_tid = '0;
    logic [7:0] enq_op = '0;
    logic [4:0] enq_dst = '0, enq_src0 = '0, enq_src1 = '0;
    logic       enq_err;
    logic [3:0] thread_full, thread_empty;
    logic [3:0] lane_busy = '0;
    logic       iss_vld;
    logic [3:0] iss_lane_sel;
    logic [1:0] iss_tid;
    logic [7:0] iss_op;
    logic [4:0] iss_dst, iss_src0, iss_src1;
    logic       wb_vld = 1'b0;
    logic [1:0] wb_tid = '0;
    logic [4:0] wb_dst = '0;

    mtp_issue_unit dut (
        .clk(clk), .reset(reset), .thread_en(thread_en),
        .enq_vld(enq_vld), .enq_tid(enq_tid), .enq_op(enq_op), .enq_dst(enq_dst),
        .enq_src0(enq_src0), .enq_src1(enq_src1), .enq_err(enq_err),
        .thread_full(thread_full), .thread_empty(thread_empty), .lane_busy(lane_busy),
        .iss_vld(iss_vld), .iss_lane_sel(iss_lane_sel), .iss_tid(iss_tid), .iss_op(iss_op),
        .iss_dst(iss_dst), .iss_src0(iss_src0), .iss_src1(iss_src1),
        .wb_vld(wb_vld), .wb_tid(wb_tid), .wb_dst(wb_dst)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] op; logic [4:0] dst, s0, s1; } ins_t;
    typedef struct packed { logic [1:0] tid; logic [3:0] lane; ins_t ins; } iss_t;
    typedef struct { int cyc; int tid; logic [3:0] lane; logic [7:0] op; } log_t;
    typedef struct { int tid; int dst; } wbp_t;

    // Reference model: per-thread instruction queues, busy-register flags,
    // round-robin start thread and the lane issued last cycle.
    ins_t       mq [NT][$];
    bit         busy [NT][32];
    int         rr;
    logic [3:0] mres;
    logic       m_err;
    iss_t       expq [$];
    log_t       ilog [$];
    wbp_t       pend [$];
    int         errors = 0, checks = 0, cyc = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int t = 0; t < NT; t++) begin
            mq[t].delete();
            for (int r = 0; r < 32; r++) busy[t][r] = 1'b0;
        end
        rr = 0; mres = '0; m_err = 1'b0;
        expq.delete();
    endfunction

    function automatic void model_step();
        bit go; int win; int lane; bit full; ins_t h; logic [3:0] freel; iss_t e;
        go = 0; win = 0; lane = -1; h = '0;
        freel = ~lane_busy & ~mres;
        for (int k = 0; k < NT; k++) begin
            int t;
            t = (rr + k) % NT;
            if (!go && thread_en[t] && mq[t].size() > 0) begin
                h = mq[t][0];
                if (!busy[t][h.dst] && !busy[t][h.s0] && !busy[t][h.s1]) begin
                    go = 1; win = t;
                end
            end
        end
        for (int l = 0; l < NL; l++) if (lane < 0 && freel[l]) lane = l;
        if (lane < 0) go = 0;
        full = enq_vld && (mq[enq_tid].size() == DEPTH);
        if (go) begin
            h = mq[win].pop_front();
            e.tid = 2'(win); e.lane = 4'b0001 << lane; e.ins = h;
            expq.push_back(e);
        end
        if (enq_vld && !full) mq[enq_tid].push_back({enq_op, enq_dst, enq_src0, enq_src1});
        m_err = enq_vld && full;
        if (wb_vld) busy[wb_tid][wb_dst] = 1'b0;
        if (go) begin
            busy[win][h.dst] = 1'b1;
            rr = (win + 1) % NT;
            mres = 4'b0001 << lane;
        end else begin
            mres = '0;
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_clear();
            else model_step();
        end
    end

    // Monitor: compares DUT outputs with the model's expectations.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            bit exp_v; iss_t e; logic [3:0] mem_e, mem_f; log_t lg; wbp_t wp;
            exp_v = expq.size() > 0;
            chk("iss_vld", iss_vld, exp_v);
            if (exp_v) begin
                e = expq.pop_front();
                if (iss_vld)
                    chk("issue", {iss_tid, iss_lane_sel, iss_op, iss_dst, iss_src0, iss_src1}, e);
            end else begin
                chk("iss_lane_sel_idle", iss_lane_sel, 4'b0000);
            end
            if (iss_vld) begin
                lg.cyc = cyc; lg.tid = int'(iss_tid); lg.lane = iss_lane_sel; lg.op = iss_op;
                ilog.push_back(lg);
                wp.tid = int'(iss_tid); wp.dst = int'(iss_dst);
                pend.push_back(wp);
            end
            for (int t = 0; t < NT; t++) begin
                mem_e[t] = (mq[t].size() == 0);
                mem_f[t] = (mq[t].size() == DEPTH);
            end
            chk("thread_empty", thread_empty, mem_e);
            chk("thread_full", thread_full, mem_f);
            chk("enq_err", enq_err, m_err);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; enq_vld = 1'b0; wb_vld = 1'b0; thread_en = '0; lane_busy = '0;
        pend.delete();
        repeat (2) tick();
        reset = 1'b1;
        ilog.delete();
    endtask

    task automatic enq(int tid, int op, int dst, int s0, int s1);
        enq_vld = 1'b1; enq_tid = 2'(tid); enq_op = 8'(op);
        enq_dst = 5'(dst); enq_src0 = 5'(s0); enq_src1 = 5'(s1);
        tick();
        enq_vld = 1'b0;
    endtask

    task automatic drive_wb_from_pend(int pct);
        if (pend.size() > 0 && $urandom_range(0, 99) < pct) begin
            int i;
            i = $urandom_range(0, pend.size() - 1);
            wb_vld = 1'b1; wb_tid = 2'(pend[i].tid); wb_dst = 5'(pend[i].dst);
            pend.delete(i);
        end else if ($urandom_range(0, 99) < 5) begin
            wb_vld = 1'b1; wb_tid = 2'($urandom_range(0, 3)); wb_dst = 5'($urandom_range(0, 7));
        end else begin
            wb_vld = 1'b0;
        end
    endtask

    initial begin
        int n, wbc;
        // Reset state
        repeat (2) tick();
        chk("rst_iss_vld", iss_vld, 0);
        chk("rst_lane_sel", iss_lane_sel, 0);
        chk("rst_payload", {iss_tid, iss_op, iss_dst, iss_src0, iss_src1}, 0);
        chk("rst_empty", thread_empty, 4'b1111);
        chk("rst_full", thread_full, 4'b0000);
        chk("rst_enq_err", enq_err, 0);

        // 1: reset while an issue is on the outputs
        do_reset();
        thread_en = 4'b0001;
        enq(0, 8'h11, 1, 0, 0);
        enq(0, 8'h12, 2, 0, 0);
        n = 0;
        while (!iss_vld && n < 10) begin tick(); n++; end
        chk("t1_saw_issue", iss_vld, 1);
        reset = 1'b0;
        #1;
        chk("t1_async_iss_vld", iss_vld, 0);
        chk("t1_async_empty", thread_empty, 4'b1111);

        // 2: overflow thread 1
        do_reset();
        for (int i = 0; i < 4; i++) enq(1, i, i, 0, 0);
        chk("t2_full", thread_full, 4'b0010);
        enq(1, 8'h55, 5, 0, 0);
        chk("t2_err_pulse", enq_err, 1);
        tick();
        chk("t2_err_clear", enq_err, 0);

        // 3: RAW hazard released by writeback
        do_reset();
        thread_en = 4'hF;
        enq(0, 8'hA1, 3, 1, 2);
        enq(0, 8'hB2, 4, 3, 5);
        repeat (5) tick();
        chk("t3_only_A", ilog.size(), 1);
        wb_vld = 1'b1; wb_tid = 2'd0; wb_dst = 5'd3; wbc = cyc;
        tick();
        wb_vld = 1'b0;
        n = 0;
        while (ilog.size() < 2 && n < 20) begin tick(); n++; end
        chk("t3_B_issued", ilog.size(), 2);
        if (ilog.size() >= 2) begin
            chk("t3_B_op", ilog[1].op, 8'hB2);
            chk("t3_B_latency", ilog[1].cyc - wbc, 2);
        end

        // 4: round-robin with lane reservation
        do_reset();
        for (int t = 0; t < 4; t++)
            for (int k = 0; k < 2; k++) enq(t, 16 * t + k, 8 + 2 * t + k, 20, 21);
        thread_en = 4'hF;
        repeat (12) tick();
        chk("t4_count", ilog.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < ilog.size()) begin
                chk($sformatf("t4_tid%0d", i), ilog[i].tid, i % 4);
                chk($sformatf("t4_lane%0d", i), ilog[i].lane, (i % 2 == 0) ? 4'b0001 : 4'b0010);
                if (i > 0) chk($sformatf("t4_gap%0d", i), ilog[i].cyc - ilog[i-1].cyc, 1);
            end
        end

        // 5: lane backpressure
        do_reset();
        enq(0, 8'h50, 1, 0, 0);
        enq(1, 8'h51, 2, 0, 0);
        lane_busy = 4'b1111; thread_en = 4'hF;
        repeat (10) tick();
        chk("t5_blocked", ilog.size(), 0);
        chk("t5_kept", thread_empty, 4'b1100);
        lane_busy = 4'b1011;
        repeat (3) tick();
        chk("t5_resumed", ilog.size() > 0, 1);
        if (ilog.size() > 0) chk("t5_lane", ilog[0].lane, 4'b0100);

        // 6: thread_en gating
        do_reset();
        for (int t = 0; t < 4; t++) enq(t, 8'h60 + t, 1, 0, 0);
        thread_en = 4'b0101;
        repeat (10) tick();
        chk("t6_count", ilog.size(), 2);
        foreach (ilog[i]) chk($sformatf("t6_tid%0d", i), (ilog[i].tid == 0) || (ilog[i].tid == 2), 1);
        chk("t6_retained", {thread_empty[3], thread_empty[1]}, 2'b00);

        // Randomized traffic
        do_reset();
        thread_en = 4'hF;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin do_reset(); thread_en = 4'hF; end
            enq_vld  = ($urandom_range(0, 99) < 45);
            enq_tid  = 2'($urandom_range(0, 3));
            enq_op   = 8'($urandom);
            enq_dst  = 5'($urandom_range(0, 7));
            enq_src0 = 5'($urandom_range(0, 7));
            enq_src1 = 5'($urandom_range(0, 7));
            drive_wb_from_pend(40);
            lane_busy = ($urandom_range(0, 99) < 15) ? 4'hF :
                        (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            if (c % 64 == 0)
                thread_en = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            tick();
        end

        // Drain: everything queued must eventually issue
        enq_vld = 1'b0; lane_busy = '0; thread_en = 4'hF;
        for (int c = 0; c < 200; c++) begin
            drive_wb_from_pend(100);
            tick();
        end
        wb_vld = 1'b0;
        tick();
        chk("drain_empty", thread_empty, 4'b1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
